// File: rtl/servo_motion_planner_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
//   Definitions shared by the servo motion planner and servo_controller.
//   - ANGLE_W / ANGLE_MAX : width and legal upper bound of an angle in degrees
//   - planner_state_t     : planner FSM states
//   - clamp_angle()       : saturates a raw angle to 0..ANGLE_MAX
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int ANGLE_W   = 8;
  localparam int ANGLE_MAX = 180;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } planner_state_t;

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    return (a > ANGLE_W'(ANGLE_MAX)) ? ANGLE_W'(ANGLE_MAX) : a;
  endfunction

endpackage

// File: rtl/servo_motion_planner_if.sv
// -----------------------------------------------------------------------------
// servo_motion_planner_if
//   Target-set command channel into the planner.
//   Handshake: a transfer happens on every rising clk edge where cmd_valid and
//   cmd_ready are both high. The master holds cmd_valid and the four targets
//   stable until that edge; cmd_ready may be dropped at any time by the slave
//   and carries no promise about future cycles.
//   Signals:
//     cmd_valid              master -> slave  target set present
//     cmd_ready              slave  -> master planner can accept
//     tgt0_angle..tgt3_angle master -> slave  base, shoulder, elbow, gripper
// -----------------------------------------------------------------------------
interface servo_motion_planner_if;
  import servo_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [ANGLE_W-1:0] tgt0_angle;
  logic [ANGLE_W-1:0] tgt1_angle;
  logic [ANGLE_W-1:0] tgt2_angle;
  logic [ANGLE_W-1:0] tgt3_angle;

  modport master (
    output cmd_valid, tgt0_angle, tgt1_angle, tgt2_angle, tgt3_angle,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, tgt0_angle, tgt1_angle, tgt2_angle, tgt3_angle,
    output cmd_ready
  );

endinterface

// File: rtl/servo_motion_planner_axis_slew.sv
// -----------------------------------------------------------------------------
// axis_slew
//   One axis of the planner: clamped target register, current-angle register
//   and a bounded step toward the target.
//   Ports:
//     clk, rst_n  clock, async active-low reset (target = angle = HOME_ANGLE)
//     load        load tgt_raw (clamped) into the target register
//     home_load   load HOME_ANGLE into the target register (wins over load)
//     tgt_raw     raw requested angle, may exceed ANGLE_MAX
//     step_en     take one bounded step toward the target this edge
//     angle       current commanded angle (registered)
//     at_target   angle equals the registered target
// -----------------------------------------------------------------------------
module axis_slew
  import servo_pkg::*;
#(
  parameter int MAX_STEP   = 1,
  parameter int HOME_ANGLE = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               home_load,
  input  logic [ANGLE_W-1:0] tgt_raw,
  input  logic               step_en,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target
);

  logic [ANGLE_W-1:0] target_q;
  logic [ANGLE_W-1:0] angle_q;
  logic               going_up;
  logic [ANGLE_W:0]   diff;
  logic [ANGLE_W-1:0] step;
  logic [ANGLE_W-1:0] angle_d;

  // Magnitude of the distance at 9 bits; direction comes from the compare so
  // the subtraction never wraps. The step is limited to the remaining
  // distance, which is what rules out overshoot.
  always_comb begin
    going_up = (angle_q < target_q);
    if (going_up) diff = {1'b0, target_q} - {1'b0, angle_q};
    else          diff = {1'b0, angle_q} - {1'b0, target_q};
    step    = (diff > (ANGLE_W+1)'(MAX_STEP)) ? ANGLE_W'(MAX_STEP) : diff[ANGLE_W-1:0];
    angle_d = going_up ? (angle_q + step) : (angle_q - step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= ANGLE_W'(HOME_ANGLE);
      angle_q  <= ANGLE_W'(HOME_ANGLE);
    end else begin
      if (home_load)  target_q <= ANGLE_W'(HOME_ANGLE);
      else if (load)  target_q <= clamp_angle(tgt_raw);
      if (step_en)    angle_q  <= angle_d;
    end
  end

  assign angle     = angle_q;
  assign at_target = (angle_q == target_q);

endmodule

// File: rtl/servo_motion_planner.sv
// -----------------------------------------------------------------------------
// servo_motion_planner
//   Rate-limited trajectory stage in front of servo_controller. Accepts 4-axis
//   target sets and slews each output by at most MAX_STEP degrees per tick
//   (STEP_HZ ticks per second) toward them. Supports homing, hold and a
//   move-complete pulse.
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     cmd                          target-set channel (slave side)
//     home                         one-cycle request: all targets -> HOME_ANGLE
//     hold                         level; freezes stepping while high
//     servo0_angle..servo3_angle   current commanded angles
//     busy                         high while in MOVE
//     done                         one-cycle pulse when a move completes
//     clamp_flag                   one-cycle pulse after an accepted target >180
//     state_dbg                    current FSM state
// -----------------------------------------------------------------------------
module servo_motion_planner
  import servo_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int STEP_HZ    = 500,
  parameter int MAX_STEP   = 1,
  parameter int HOME_ANGLE = 90
) (
  input  logic                 clk,
  input  logic                 rst_n,
  servo_motion_planner_if.slave cmd,
  input  logic                 home,
  input  logic                 hold,
  output logic [ANGLE_W-1:0]   servo0_angle,
  output logic [ANGLE_W-1:0]   servo1_angle,
  output logic [ANGLE_W-1:0]   servo2_angle,
  output logic [ANGLE_W-1:0]   servo3_angle,
  output logic                 busy,
  output logic                 done,
  output logic                 clamp_flag,
  output planner_state_t       state_dbg
);

  localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Free-running tick divider; commands never restart it, so the first step
  // after an accept lands anywhere from 1 to TICK_DIV cycles later.
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  planner_state_t state_q;
  logic           accept;
  logic           over_range;
  logic           step_en;
  logic [3:0]     at_tgt;
  logic           all_at;
  logic [ANGLE_W-1:0] tgt_raw [4];
  logic [ANGLE_W-1:0] angle   [4];

  assign cmd.cmd_ready = (state_q == IDLE) && !home;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign over_range    = (cmd.tgt0_angle > ANGLE_W'(ANGLE_MAX)) ||
                         (cmd.tgt1_angle > ANGLE_W'(ANGLE_MAX)) ||
                         (cmd.tgt2_angle > ANGLE_W'(ANGLE_MAX)) ||
                         (cmd.tgt3_angle > ANGLE_W'(ANGLE_MAX));
  // Only MOVE steps, so a tick on the accept edge (still IDLE) is ignored.
  assign step_en       = tick && (state_q == MOVE) && !hold;
  assign all_at        = &at_tgt;

  assign tgt_raw[0] = cmd.tgt0_angle;
  assign tgt_raw[1] = cmd.tgt1_angle;
  assign tgt_raw[2] = cmd.tgt2_angle;
  assign tgt_raw[3] = cmd.tgt3_angle;

  for (genvar i = 0; i < 4; i++) begin : g_axis
    axis_slew #(
      .MAX_STEP   (MAX_STEP),
      .HOME_ANGLE (HOME_ANGLE)
    ) u_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .home_load (home),
      .tgt_raw   (tgt_raw[i]),
      .step_en   (step_en),
      .angle     (angle[i]),
      .at_target (at_tgt[i])
    );
  end

  // Completion is checked every MOVE cycle regardless of hold, so a move that
  // is already at target exits even while held. Home restarts MOVE and
  // suppresses a coincident completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done       <= 1'b0;
      clamp_flag <= 1'b0;
    end else begin
      done       <= 1'b0;
      clamp_flag <= 1'b0;
      if (home) begin
        state_q <= MOVE;
      end else if (accept) begin
        state_q    <= MOVE;
        clamp_flag <= over_range;
      end else if ((state_q == MOVE) && all_at) begin
        state_q <= IDLE;
        done    <= 1'b1;
      end
    end
  end

  assign servo0_angle = angle[0];
  assign servo1_angle = angle[1];
  assign servo2_angle = angle[2];
  assign servo3_angle = angle[3];
  assign busy         = (state_q == MOVE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_servo_motion_planner.sv
// -----------------------------------------------------------------------------
// tb_servo_motion_planner
//   Directed bench for servo_motion_planner with TICK_DIV = 10, MAX_STEP = 2,
//   HOME_ANGLE = 90. The bench keeps its own cycle counter since reset release
//   so accepts can be placed at a known tick phase; with the accept on the
//   cycle where that counter reaches 3 (mod 10), steps land 7, 17, 27, ...
//   cycles later and done is seen one cycle after the final step.
// -----------------------------------------------------------------------------
module tb_servo_motion_planner;
  import servo_pkg::*;

  logic clk;
  logic rst_n;
  logic home;
  logic hold;
  logic [7:0] servo0_angle, servo1_angle, servo2_angle, servo3_angle;
  logic busy, done, clamp_flag;
  planner_state_t state_dbg;

  servo_motion_planner_if cmd_if ();

  servo_motion_planner #(
    .CLK_FREQ   (1000),
    .STEP_HZ    (100),
    .MAX_STEP   (2),
    .HOME_ANGLE (90)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if.slave),
    .home         (home),
    .hold         (hold),
    .servo0_angle (servo0_angle),
    .servo1_angle (servo1_angle),
    .servo2_angle (servo2_angle),
    .servo3_angle (servo3_angle),
    .busy         (busy),
    .done         (done),
    .clamp_flag   (clamp_flag),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [31:0] ang;
  assign ang = {servo3_angle, servo2_angle, servo1_angle, servo0_angle};

  localparam logic [31:0] ALL_HOME = {8'd90, 8'd90, 8'd90, 8'd90};

  int vectors;
  int miscompares;
  logic [31:0] step_q[$];

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3,
                        input bit align, output bit accepted, output bit clamp_seen);
    @(negedge clk);
    if (align) begin
      while ((cyc % 10) != 2) @(negedge clk);
    end
    cmd_if.tgt0_angle = a0;
    cmd_if.tgt1_angle = a1;
    cmd_if.tgt2_angle = a2;
    cmd_if.tgt3_angle = a3;
    cmd_if.cmd_valid  = 1'b1;
    #1 accepted = cmd_if.cmd_ready;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    clamp_seen = clamp_flag;
  endtask

  // Follows a move until done, recording every change of the angle vector.
  // n is the number of cycles after the accept at which done was first seen.
  task automatic wait_done(input int budget, output int n, output int done_cnt,
                           output int clamp_cnt, output bit timeout);
    logic [31:0] prev;
    step_q.delete();
    prev = ang;
    n = 0; done_cnt = 0; clamp_cnt = 0; timeout = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ang !== prev) begin
        step_q.push_back(ang);
        prev = ang;
      end
      if (clamp_flag) clamp_cnt++;
      if (done) begin
        done_cnt++;
        n = i;
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int done_seen;
    rst_n = 1'b0;
    home = 1'b0; hold = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.tgt0_angle = 8'd0; cmd_if.tgt1_angle = 8'd0;
    cmd_if.tgt2_angle = 8'd0; cmd_if.tgt3_angle = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    vectors++;
    if (ang !== ALL_HOME) begin
      miscompares++; $display("FAIL reset_angles: got %h want %h", ang, ALL_HOME);
    end
    vectors++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++; $display("FAIL reset_idle_done: got %0d pulses want 0", done_seen);
    end
    vectors++;
    if (state_dbg !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d want IDLE", state_dbg);
    end
  endtask

  task automatic test_move();
    bit acc, clk_seen, to;
    int n, dc, cc;
    logic [31:0] exp_q[$];
    exp_q = '{{8'd92, 8'd88, 8'd90, 8'd92},
              {8'd94, 8'd86, 8'd90, 8'd94},
              {8'd95, 8'd84, 8'd90, 8'd96},
              {8'd95, 8'd82, 8'd90, 8'd98},
              {8'd95, 8'd80, 8'd90, 8'd100}};
    do_cmd(8'd100, 8'd90, 8'd80, 8'd95, 1'b1, acc, clk_seen);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++; $display("FAIL move_accept: ready %b want 1", acc);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL move_busy: got %b want 1", busy);
    end
    vectors++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL move_ready_low: got %b want 0", cmd_if.cmd_ready);
    end
    wait_done(100, n, dc, cc, to);
    vectors++;
    if (to) begin
      miscompares++; $display("FAIL move_timeout: no done within 100 cycles");
    end
    vectors++;
    if (step_q.size() != 5) begin
      miscompares++; $display("FAIL move_step_count: got %0d want 5", step_q.size());
    end
    for (int k = 0; k < 5 && k < step_q.size(); k++) begin
      vectors++;
      if (step_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL move_step%0d: got %h want %h", k + 1, step_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (n != 48) begin
      miscompares++; $display("FAIL move_latency: got %0d cycles want 48", n);
    end
    vectors++;
    if (dc != 1) begin
      miscompares++; $display("FAIL move_done_pulses: got %0d want 1", dc);
    end
    vectors++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL move_end_idle: ready %b busy %b want 1 0", cmd_if.cmd_ready, busy);
    end
  endtask

  task automatic test_same_position();
    bit acc, cs, to;
    int n, dc, cc;
    do_cmd(8'd100, 8'd90, 8'd80, 8'd95, 1'b0, acc, cs);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL same_pos_busy: got %b want 1", busy);
    end
    wait_done(20, n, dc, cc, to);
    vectors++;
    if (to || n != 1 || dc != 1 || step_q.size() != 0) begin
      miscompares++;
      $display("FAIL same_pos_done: timeout %b n %0d pulses %0d steps %0d want 0 1 1 0",
               to, n, dc, step_q.size());
    end
  endtask

  task automatic test_clamp();
    bit acc, cs, to;
    int n, dc, cc, bad;
    do_cmd(8'd100, 8'd250, 8'd80, 8'd95, 1'b1, acc, cs);
    vectors++;
    if (cs !== 1'b1) begin
      miscompares++; $display("FAIL clamp_flag: got %b want 1", cs);
    end
    wait_done(600, n, dc, cc, to);
    vectors++;
    if (to || cc != 0) begin
      miscompares++; $display("FAIL clamp_once: timeout %b extra pulses %0d want 0 0", to, cc);
    end
    vectors++;
    if (step_q.size() != 45) begin
      miscompares++; $display("FAIL clamp_step_count: got %0d want 45", step_q.size());
    end
    bad = 0;
    for (int k = 0; k < step_q.size(); k++)
      if (step_q[k][15:8] !== 8'(90 + 2 * (k + 1))) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL clamp_ramp: got %0d wrong steps want 0", bad);
    end
    vectors++;
    if (servo1_angle !== 8'd180 || n != 448 || dc != 1) begin
      miscompares++;
      $display("FAIL clamp_end: angle %0d n %0d pulses %0d want 180 448 1", servo1_angle, n, dc);
    end
  endtask

  task automatic test_hold();
    bit acc, cs, to, frozen_bad, hold_done;
    int n, dc, cc, steps, done_n, hold_start;
    logic [31:0] prev, held;
    // baseline: 10 degrees on axis 0
    do_cmd(8'd110, 8'd180, 8'd80, 8'd95, 1'b1, acc, cs);
    wait_done(100, n, dc, cc, to);
    vectors++;
    if (to || n != 48) begin
      miscompares++; $display("FAIL hold_baseline: timeout %b n %0d want 0 48", to, n);
    end
    // same distance back, held for three ticks after the second step
    do_cmd(8'd100, 8'd180, 8'd80, 8'd95, 1'b1, acc, cs);
    prev = ang; held = ang;
    steps = 0; done_n = 0; hold_start = 0;
    frozen_bad = 1'b0; hold_done = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ang !== prev) begin
        steps++;
        prev = ang;
      end
      if (hold && ang !== held) frozen_bad = 1'b1;
      if (done) begin
        done_n = i;
        break;
      end
      if (!hold && !hold_done && steps == 2) begin
        hold = 1'b1;
        held = ang;
        hold_start = i;
      end else if (hold && i == hold_start + 30) begin
        hold = 1'b0;
        hold_done = 1'b1;
      end
    end
    hold = 1'b0;
    vectors++;
    if (frozen_bad) begin
      miscompares++; $display("FAIL hold_frozen: angles moved during hold (held %h)", held);
    end
    vectors++;
    if (done_n != 78 || steps != 5) begin
      miscompares++; $display("FAIL hold_latency: done at %0d steps %0d want 78 5", done_n, steps);
    end
    vectors++;
    if (ang !== {8'd95, 8'd80, 8'd180, 8'd100}) begin
      miscompares++; $display("FAIL hold_end: got %h want %h", ang, {8'd95, 8'd80, 8'd180, 8'd100});
    end
  endtask

  task automatic test_home();
    bit acc, cs, to, found;
    int n, dc, cc;
    do_cmd(8'd150, 8'd180, 8'd80, 8'd95, 1'b1, acc, cs);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (servo0_angle == 8'd104) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL home_premove: axis0 %0d want 104", servo0_angle);
    end
    home = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.tgt0_angle = 8'd10; cmd_if.tgt1_angle = 8'd10;
    cmd_if.tgt2_angle = 8'd10; cmd_if.tgt3_angle = 8'd10;
    #1;
    vectors++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL home_ready: got %b want 0", cmd_if.cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    home = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL home_busy: got %b want 1", busy);
    end
    wait_done(600, n, dc, cc, to);
    vectors++;
    if (to || dc != 1 || cc != 0) begin
      miscompares++; $display("FAIL home_done: timeout %b pulses %0d clamps %0d want 0 1 0", to, dc, cc);
    end
    vectors++;
    if (ang !== ALL_HOME) begin
      miscompares++; $display("FAIL home_angles: got %h want %h", ang, ALL_HOME);
    end
  endtask

  task automatic test_reset_mid_move();
    bit acc, cs;
    do_cmd(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, acc, cs);
    repeat (25) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || ang === ALL_HOME) begin
      miscompares++; $display("FAIL rst_premove: busy %b angles %h want 1 and moved", busy, ang);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (ang !== ALL_HOME) begin
      miscompares++; $display("FAIL rst_async_angles: got %h want %h", ang, ALL_HOME);
    end
    vectors++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || clamp_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async_flags: ready %b busy %b done %b clamp %b want 1 0 0 0",
               cmd_if.cmd_ready, busy, done, clamp_flag);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    vectors++;
    if (state_dbg !== IDLE || ang !== ALL_HOME || cmd_if.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release: state %0d angles %h ready %b want IDLE %h 1",
               state_dbg, ang, cmd_if.cmd_ready, ALL_HOME);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_move();
    test_same_position();
    test_clamp();
    test_hold();
    test_home();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
